// File: rtl/bcd_serial_addsub.sv
// bcd_serial_addsub: digit-serial packed-BCD add/subtract, LS digit first, with a start/busy/done handshake.
// Subtraction adds the 9's complement of b, so the decimal carry doubles as an inverted borrow.
module bcd_serial_addsub #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                op_sub,
    input  logic                ci,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] sum,
    output logic                co,
    output logic                invalid
);
    localparam int W  = 4*DIGITS;
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_nx;
    logic [W-1:0]    a_q, b_q, res, res_nx;
    logic [IW-1:0]   idx;
    logic            sub_q, c, bad, bad_in, last, cn;
    logic [3:0]      ad, bd, s;
    logic [4:0]      z;

    always_comb begin
        bad_in = 1'b0;
        for (int i = 0; i < DIGITS; i++)
            if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) bad_in = 1'b1;
    end

    always_comb begin
        ad     = a_q[{idx, 2'b00} +: 4];
        bd     = sub_q ? 4'd9 - b_q[{idx, 2'b00} +: 4] : b_q[{idx, 2'b00} +: 4];
        z      = {1'b0, ad} + {1'b0, bd} + {4'b0, c};
        cn     = z > 5'd9;
        s      = cn ? z[3:0] + 4'd6 : z[3:0];
        res_nx = res;
        res_nx[{idx, 2'b00} +: 4] = s;
        // a rejected operand spends its single RUN cycle only to keep the fixed two-edge latency
        last   = bad || (idx == IW'(DIGITS-1));
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? RUN : IDLE;
            RUN:     state_nx = last ? DONE : RUN;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            res     <= '0;
            idx     <= '0;
            sub_q   <= 1'b0;
            c       <= 1'b0;
            bad     <= 1'b0;
            sum     <= '0;
            co      <= 1'b0;
            invalid <= 1'b0;
        end else if (state == IDLE && start) begin
            a_q   <= a;
            b_q   <= b;
            sub_q <= op_sub;
            c     <= ci ^ op_sub;
            bad   <= bad_in;
            idx   <= '0;
        end else if (state == RUN) begin
            res <= res_nx;
            c   <= cn;
            idx <= idx + 1'b1;
            if (last) begin
                sum     <= bad ? '0 : res_nx;
                co      <= ~bad & (cn ^ sub_q);
                invalid <= bad;
                idx     <= '0;
            end
        end
    end

    assign busy = state != IDLE;
    assign done = state == DONE;
endmodule

// File: tb/tb_bcd_serial_addsub.sv
// tb_bcd_serial_addsub: directed table, random ops against a decimal-arithmetic model,
// and hand sequences for held start and mid-operation reset.
module tb_bcd_serial_addsub;
    localparam int DIGITS = 4;
    localparam int W = 4*DIGITS;

    logic         clk = 0, rst_n = 0, start = 0, op_sub = 0, ci = 0;
    logic [W-1:0] a = '0, b = '0, sum;
    logic         busy, done, co, invalid;
    int           errs = 0, checks = 0;

    typedef struct {
        logic [W-1:0] a, b;
        logic         sub, ci;
        logic [W-1:0] s;
        logic         co, inv;
        int           lat;
    } vec_t;
    vec_t tbl[10];

    bcd_serial_addsub #(.DIGITS(DIGITS)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op_sub(op_sub), .ci(ci),
        .a(a), .b(b), .busy(busy), .done(done), .sum(sum), .co(co), .invalid(invalid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic is,
                                  input logic ic, output logic [W-1:0] es, output logic eco,
                                  output logic einv);
        longint av = 0, bv = 0, m = 1, r;
        bit bad = 0;
        for (int i = DIGITS-1; i >= 0; i--) begin
            if (ia[4*i +: 4] > 9 || ib[4*i +: 4] > 9) bad = 1;
            av = av*10 + ia[4*i +: 4];
            bv = bv*10 + ib[4*i +: 4];
            m  = m*10;
        end
        es = '0;
        eco = 0;
        einv = bad;
        if (bad) return;
        r   = is ? av - bv - ic : av + bv + ic;
        eco = is ? (r < 0) : (r >= m);
        r   = ((r % m) + m) % m;
        for (int i = 0; i < DIGITS; i++) begin
            es[4*i +: 4] = 4'(r % 10);
            r = r / 10;
        end
    endfunction

    task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic is, input logic ic,
                          input logic [W-1:0] es, input logic eco, input logic einv, input int elat);
        int n = 0;
        bit got = 0;
        @(negedge clk);
        a = ia; b = ib; op_sub = is; ci = ic; start = 1;
        @(posedge clk);
        #1 start = 0;
        a = W'($urandom); b = W'($urandom); op_sub = 1'($urandom); ci = 1'($urandom);
        while (!got && n < 20) begin
            @(posedge clk);
            n++;
            #1;
            if (done) got = 1;
            else chk("busy_wait", busy, 1);
        end
        chk("done_seen", got, 1);
        chk("latency", n, elat);
        chk("sum", sum, es);
        chk("co", co, eco);
        chk("invalid", invalid, einv);
        chk("busy_in_done", busy, 1);
        @(posedge clk);
        #1;
        chk("busy_after", busy, 0);
        chk("done_after", done, 0);
    endtask

    initial begin
        logic [W-1:0] ra, rb, es;
        logic rs, rc, eco, einv;
        int dn;

        tbl[0] = '{16'h0999, 16'h0001, 0, 0, 16'h1000, 0, 0, 4};
        tbl[1] = '{16'h9999, 16'h0001, 0, 0, 16'h0000, 1, 0, 4};
        tbl[2] = '{16'h0009, 16'h0000, 0, 1, 16'h0010, 0, 0, 4};
        tbl[3] = '{16'h1000, 16'h0001, 1, 0, 16'h0999, 0, 0, 4};
        tbl[4] = '{16'h0001, 16'h0002, 1, 0, 16'h9999, 1, 0, 4};
        tbl[5] = '{16'h0005, 16'h0005, 1, 1, 16'h9999, 1, 0, 4};
        tbl[6] = '{16'h00A0, 16'h0001, 0, 0, 16'h0000, 0, 1, 1};
        tbl[7] = '{16'h9999, 16'h9999, 0, 1, 16'h9999, 1, 0, 4};
        tbl[8] = '{16'h0000, 16'h0000, 1, 0, 16'h0000, 0, 0, 4};
        tbl[9] = '{16'h1234, 16'h000F, 1, 0, 16'h0000, 0, 1, 1};

        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum, 0);
        chk("rst_co", co, 0);
        chk("rst_invalid", invalid, 0);
        rst_n = 1;

        for (int i = 0; i < 10; i++)
            run_op(tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].ci, tbl[i].s, tbl[i].co, tbl[i].inv, tbl[i].lat);

        for (int i = 0; i < 40; i++) begin
            for (int d = 0; d < DIGITS; d++) begin
                ra[4*d +: 4] = 4'($urandom_range(0, 9));
                rb[4*d +: 4] = 4'($urandom_range(0, 9));
            end
            if ($urandom_range(0, 7) == 0) ra[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
            rs = 1'($urandom);
            rc = 1'($urandom);
            model(ra, rb, rs, rc, es, eco, einv);
            run_op(ra, rb, rs, rc, es, eco, einv, einv ? 1 : DIGITS);
        end

        // start held high: one done per op, second op latched on first IDLE edge
        dn = 0;
        @(negedge clk);
        a = 16'h1234; b = 16'h1111; op_sub = 0; ci = 0; start = 1;
        @(posedge clk);
        #1 a = 16'h5000; b = 16'h5001;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk);
            #1;
            chk("held_done_at", done, (n == 4 || n == 10));
            if (done) dn++;
            if (n == 4) chk("held_sum1", sum, 16'h2345);
            if (n == 10) begin
                chk("held_sum2", sum, 16'h0001);
                chk("held_co2", co, 1);
            end
        end
        start = 0;
        chk("held_done_count", dn, 2);
        @(posedge clk);
        #1 chk("held_busy_after", busy, 0);

        // reset mid-run at idx=2
        @(negedge clk);
        a = 16'h1234; b = 16'h1111; op_sub = 0; ci = 0; start = 1;
        @(posedge clk);
        #1 start = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_sum", sum, 0);
        chk("mid_rst_co", co, 0);
        chk("mid_rst_invalid", invalid, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        for (int n = 0; n < 3; n++) begin
            @(posedge clk);
            #1 chk("post_rst_no_done", done, 0);
        end
        run_op(16'h1234, 16'h8766, 0, 0, 16'h0000, 1, 0, 4);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
